// File: rtl/interval_timer.sv
// interval_timer: interval countdown engine fed by the traffic-light time-parameter store.
// A start request selects an interval, then the timer waits one cycle for the
// store's registered lookup and captures the returned duration. The duration
// is counted down on 1 Hz ticks, and expiry is signalled with a one-cycle pulse.
module interval_timer #(
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start_timer,
    input  logic [1:0]             interval_sel,
    input  logic                   abort,
    input  logic                   tick,
    input  logic [COUNT_WIDTH-1:0] value,
    output logic [1:0]             interval,
    output logic                   busy,
    output logic                   expired,
    output logic [COUNT_WIDTH-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        LOAD = 2'b10,
        RUN  = 2'b11
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [1:0]             interval_q, interval_d;
    logic                   busy_q, busy_d;
    logic                   expired_q, expired_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;

    // Next-state and output computation; abort overrides every other transition.
    always_comb begin
        state_d     = state_q;
        interval_d  = interval_q;
        busy_d      = busy_q;
        expired_d   = 1'b0;
        remaining_d = remaining_q;

        if (abort) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            remaining_d = CNT_ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    // Select 11 has no stored duration, so the request is dropped.
                    if (start_timer && (interval_sel != 2'b11)) begin
                        interval_d = interval_sel;
                        busy_d     = 1'b1;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    // The store registers its lookup of interval during this cycle.
                    state_d = LOAD;
                end
                LOAD: begin
                    remaining_d = value;
                    if (value == CNT_ZERO) begin
                        expired_d = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (remaining_q > CNT_ONE) begin
                            remaining_d = remaining_q - CNT_ONE;
                        end else begin
                            // Final tick: the count reaches zero and never wraps.
                            remaining_d = CNT_ZERO;
                            expired_d   = 1'b1;
                            busy_d      = 1'b0;
                            state_d     = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs, cleared asynchronously by reset_n.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            interval_q  <= 2'b00;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
            remaining_q <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            interval_q  <= interval_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
            remaining_q <= remaining_d;
        end
    end

    assign interval  = interval_q;
    assign busy      = busy_q;
    assign expired   = expired_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: directed bench for interval_timer with a behavioral
// registered parameter store (defaults 6/3/2) feeding the value input.
module tb_interval_timer;

    localparam int CW = 4;

    logic          clock;
    logic          reset_n;
    logic          start_timer;
    logic [1:0]    interval_sel;
    logic          abort;
    logic          tick;
    logic [CW-1:0] value;
    logic [1:0]    interval;
    logic          busy;
    logic          expired;
    logic [CW-1:0] remaining;

    logic [CW-1:0] store [4];

    int n_checks;
    int n_fail;

    interval_timer #(.COUNT_WIDTH(CW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start_timer (start_timer),
        .interval_sel(interval_sel),
        .abort       (abort),
        .tick        (tick),
        .value       (value),
        .interval    (interval),
        .busy        (busy),
        .expired     (expired),
        .remaining   (remaining)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Parameter store: one-cycle registered lookup of the selected interval.
    always @(posedge clock) value <= store[interval];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        store[0] = 4'd6;
        store[1] = 4'd3;
        store[2] = 4'd2;
        store[3] = 4'd0;
        reset_n      = 1'b0;
        start_timer  = 1'b0;
        interval_sel = 2'b00;
        abort        = 1'b0;
        tick         = 1'b0;

        // Reset state
        #3;
        check("rst_interval", interval, 0);
        check("rst_busy", busy, 0);
        check("rst_expired", expired, 0);
        check("rst_remaining", remaining, 0);
        cyc();
        reset_n = 1'b1;

        // Base interval, tick every cycle
        start_timer = 1'b1; interval_sel = 2'b00; tick = 1'b1;
        cyc();
        check("t1_interval", interval, 0);
        check("t1_busy", busy, 1);
        start_timer = 1'b0;
        cyc();
        cyc();
        check("t1_load", remaining, 6);
        for (int k = 5; k >= 0; k--) begin
            cyc();
            check("t1_rem", remaining, k);
            check("t1_exp", expired, (k == 0) ? 1 : 0);
            check("t1_busy_run", busy, (k != 0) ? 1 : 0);
        end
        tick = 1'b0;
        cyc();
        check("t1_exp_clear", expired, 0);

        // Yellow, tick every 4th cycle; the tick on the LOAD edge is lost
        start_timer = 1'b1; interval_sel = 2'b10;
        cyc();
        check("t2_interval", interval, 2);
        start_timer = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick = ((k % 4) == 2);
            cyc();
            check("t2_rem", remaining, (k < 2) ? 0 : (k < 6) ? 2 : (k < 10) ? 1 : 0);
            check("t2_exp", expired, (k == 10) ? 1 : 0);
            check("t2_busy", busy, (k < 10) ? 1 : 0);
        end
        tick = 1'b0;

        // Zero-length extension interval
        store[1] = 4'd0;
        start_timer = 1'b1; interval_sel = 2'b01; tick = 1'b1;
        cyc();
        check("t3_interval", interval, 1);
        check("t3_busy", busy, 1);
        start_timer = 1'b0;
        cyc();
        check("t3_wait_exp", expired, 0);
        cyc();
        check("t3_exp", expired, 1);
        check("t3_rem", remaining, 0);
        check("t3_busy_low", busy, 0);
        cyc();
        check("t3_exp_clear", expired, 0);
        check("t3_idle_rem", remaining, 0);
        tick = 1'b0;

        // Illegal select is ignored
        start_timer = 1'b1; interval_sel = 2'b11;
        cyc();
        check("t4_ill_busy", busy, 0);
        check("t4_ill_interval", interval, 1);
        // Start during RUN is ignored
        interval_sel = 2'b00;
        cyc();
        start_timer = 1'b0;
        cyc();
        cyc();
        check("t4_load", remaining, 6);
        start_timer = 1'b1; interval_sel = 2'b10; tick = 1'b1;
        cyc();
        check("t4_run_rem", remaining, 5);
        check("t4_run_interval", interval, 0);
        check("t4_run_busy", busy, 1);
        start_timer = 1'b0;
        repeat (4) cyc();
        check("t4_rem_one", remaining, 1);

        // Abort with the final tick: no expiry pulse
        abort = 1'b1;
        cyc();
        check("t5_abort_exp", expired, 0);
        check("t5_abort_rem", remaining, 0);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_interval", interval, 0);
        abort = 1'b0; tick = 1'b0;
        cyc();
        check("t5_after_exp", expired, 0);
        check("t5_after_busy", busy, 0);

        // Asynchronous reset mid-RUN
        start_timer = 1'b1; interval_sel = 2'b10;
        cyc();
        start_timer = 1'b0;
        cyc();
        cyc();
        check("t6_load", remaining, 2);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        check("t6_rem", remaining, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_interval", interval, 0);
        check("t6_rst_rem", remaining, 0);
        check("t6_rst_exp", expired, 0);
        #1;
        reset_n = 1'b1;
        cyc();
        check("t6_post_exp", expired, 0);
        check("t6_post_busy", busy, 0);

        // Back-to-back: start yellow in the expiry cycle of a base interval
        start_timer = 1'b1; interval_sel = 2'b00; tick = 1'b1;
        cyc();
        start_timer = 1'b0;
        cyc();
        cyc();
        check("t7_load", remaining, 6);
        repeat (6) cyc();
        check("t7_exp", expired, 1);
        check("t7_busy_low", busy, 0);
        start_timer = 1'b1; interval_sel = 2'b10;
        cyc();
        check("t7_b2b_interval", interval, 2);
        check("t7_b2b_busy", busy, 1);
        check("t7_b2b_exp", expired, 0);
        start_timer = 1'b0;
        cyc();
        cyc();
        check("t7_b2b_load", remaining, 2);
        cyc();
        check("t7_b2b_rem", remaining, 1);
        cyc();
        check("t7_b2b_rem0", remaining, 0);
        check("t7_b2b_exp2", expired, 1);
        tick = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
# interval_timer

Countdown engine that consumes the interval durations held by the traffic-light time-parameter store. On a start request it drives the 2-bit interval select to the store, waits out the store's registered read latency, captures the returned duration, and counts it down on 1 Hz ticks. When the count is exhausted it pulses `expired` to the phase controller.

## Interface
**Parameters**
- `COUNT_WIDTH`, default 4: width of the duration value and the down-counter. Must equal the store's `value` width.

**Ports**
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_timer`  in  1  request to time one interval. Sampled only in IDLE.
- `interval_sel`  in  2  interval to time: 00 base, 01 extension, 10 yellow, 11 illegal.
- `abort`  in  1  cancel the current interval. Highest priority.
- `tick`  in  1  one-cycle 1 Hz enable strobe.
- `value`  in  COUNT_WIDTH  duration returned by the parameter store.
- `interval`  out  2  registered interval select driven to the parameter store.
- `busy`  out  1  high from start acceptance until expiry or abort.
- `expired`  out  1  one-cycle pulse when the interval completes.
- `remaining`  out  COUNT_WIDTH  current down-count, for display.

## Operation
- States: IDLE, WAIT, LOAD, RUN.
- Reset (asynchronous, `reset_n` = 0) forces:
  - state = IDLE
  - `interval` = 00
  - `busy` = 0
  - `expired` = 0
  - `remaining` = 0
- IDLE:
  - If `start_timer` = 1 and `interval_sel` ≠ 11: `interval` <= `interval_sel`, `busy` <= 1, go to WAIT.
  - If `start_timer` = 1 and `interval_sel` = 11: ignore the request. Stay in IDLE, `busy` stays 0, `interval` unchanged.
- WAIT: one cycle unconditionally, then LOAD. This covers the store's registered lookup of `interval`.
- LOAD:
  - `remaining` <= `value`.
  - If `value` = 0: `expired` <= 1, `busy` <= 0, go to IDLE (zero-length interval).
  - Otherwise go to RUN.
- RUN:
  - On `tick` with `remaining` > 1: `remaining` <= `remaining` − 1.
  - On `tick` with `remaining` = 1: `remaining` <= 0, `expired` <= 1, `busy` <= 0, go to IDLE.
  - No tick: hold state and count.
- `expired` is asserted only by the transitions above. It is cleared on the next edge.
- `tick` is ignored outside RUN. A tick coincident with the LOAD edge is lost.
- `start_timer` is ignored in WAIT, LOAD and RUN. There is no queueing.
- `abort` = 1 in any state:
  - Next edge: state = IDLE, `busy` = 0, `remaining` = 0, `expired` = 0.
  - `interval` holds its last value.
  - Abort overrides a simultaneous final tick or zero-value load, so no expiry pulse is produced.
- `interval` stays stable from acceptance through RUN. Reprogramming the store during RUN has no effect on the captured count.
- Arithmetic is unsigned COUNT_WIDTH. `remaining` never decrements below 0 and never wraps.

## Timing
- E0 = the edge at which `start_timer` is accepted in IDLE.
- After E0: `interval` and `busy` = 1 valid.
- E1: WAIT → LOAD. The store registers `value` for the new `interval` at this edge.
- E2: `remaining` = `value` becomes visible; state = RUN.
- Ticks are counted from E3 onward.
- With duration N ≥ 1 and a tick on every cycle: the final decrement occurs at edge E(2+N), and `expired` is high for exactly the cycle following that edge.
- The cycle in which `expired` is high is already IDLE, so a new `start_timer` in that cycle is accepted. This gives back-to-back intervals with a 3-cycle gap before the next count begins.
- With duration 0: `expired` is high in the cycle after E2.
- Reset asserted mid-interval clears outputs immediately, independent of `clock`. No expiry pulse is produced.

## Test plan
- Reset, then `interval_sel` = 00 with the store at defaults (6/3/2), tick every cycle:
  - `interval` = 00 after E0; `remaining` = 6 after E2.
  - `remaining` counts 5,4,3,2,1,0; `expired` is high 1 cycle after E8; `busy` falls with it.
- Yellow (10), tick every 4th cycle: `remaining` holds between ticks; exactly 2 ticks in RUN produce one `expired` pulse. Ticks during WAIT/LOAD do not decrement.
- Program extension to 0, then start 01: `expired` is high the cycle after E2, `remaining` = 0, and RUN is never entered.
- `interval_sel` = 11 with `start_timer`: `busy` stays 0 and `interval` is unchanged. Then `start_timer` during RUN: ignored, count unaffected.
- `abort` together with the final tick (`remaining` = 1): no `expired` pulse; IDLE, `remaining` = 0. Then asynchronous `reset_n` low mid-RUN: all outputs zero immediately.
- Back-to-back: start 10 in the `expired` cycle of a base interval. It is accepted, `interval` = 10, and the new count of 2 loads 2 edges later.
